// File: rtl/seq_divider_if.sv
// Operand/result bundle for the sequential divider: request fields from the
// issuing datapath, results and status back from the divider.
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [5:0]       Funct;
  logic [WIDTH-1:0] Src1;
  logic [WIDTH-1:0] Src2;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             Busy;
  logic             Done;
  logic             DivZero;

  modport master (
    output Start, Funct, Src1, Src2,
    input  Quotient, Remainder, Busy, Done, DivZero
  );

  modport slave (
    input  Start, Funct, Src1, Src2,
    output Quotient, Remainder, Busy, Done, DivZero
  );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, results
// held in output registers until the next completed operation.
module seq_divider #(
  parameter int         WIDTH      = 32,
  parameter logic [5:0] FUNCT_DIVU = 6'b011011
) (
  input logic          Clk,
  input logic          Reset,
  seq_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] p_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] quot_reg;
  logic [WIDTH-1:0] rem_reg;
  logic             div_zero_reg;

  logic             accept;
  logic             zero_div;
  logic             last_iter;
  logic [WIDTH:0]   shift_p;
  logic             ge;
  logic [WIDTH-1:0] diff_p;
  logic [WIDTH-1:0] p_next;
  logic [WIDTH-1:0] a_next;

  assign accept    = (state_reg == IDLE) && bus.Start && (bus.Funct == FUNCT_DIVU);
  assign zero_div  = (d_reg == '0);
  assign last_iter = (count_reg == CW'(1));

  // The partial remainder is always below the divisor, so only the shifted
  // value needs the extra bit; the difference fits back into WIDTH bits.
  assign shift_p = {p_reg, a_reg[WIDTH-1]};
  assign ge      = (shift_p >= {1'b0, d_reg});
  assign diff_p  = shift_p[WIDTH-1:0] - d_reg;
  assign p_next  = ge ? diff_p : shift_p[WIDTH-1:0];
  assign a_next  = {a_reg[WIDTH-2:0], ge};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (zero_div || last_iter) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count_reg    <= '0;
      p_reg        <= '0;
      a_reg        <= '0;
      d_reg        <= '0;
      quot_reg     <= '0;
      rem_reg      <= '0;
      div_zero_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            a_reg     <= bus.Src1;
            d_reg     <= bus.Src2;
            p_reg     <= '0;
            count_reg <= CW'(WIDTH);
          end
        end
        RUN: begin
          // a_reg still holds the untouched dividend on the first RUN edge
          if (zero_div) begin
            quot_reg     <= '1;
            rem_reg      <= a_reg;
            div_zero_reg <= 1'b1;
            count_reg    <= '0;
          end else begin
            p_reg     <= p_next;
            a_reg     <= a_next;
            count_reg <= count_reg - CW'(1);
            if (last_iter) begin
              quot_reg     <= a_next;
              rem_reg      <= p_next;
              div_zero_reg <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Quotient  = quot_reg;
  assign bus.Remainder = rem_reg;
  assign bus.DivZero   = div_zero_reg;
  assign bus.Busy      = (state_reg == RUN);
  assign bus.Done      = (state_reg == FIN);
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: expected results queued at request time,
// popped and compared whenever Done is observed.
module tb_seq_divider;
  localparam int         W    = 32;
  localparam logic [5:0] DIVU = 6'b011011;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } res_t;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W), .FUNCT_DIVU(DIVU)) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus.slave)
  );

  res_t         exp_q[$];
  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] last_q   = '0;
  logic [W-1:0] last_r   = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    res_t e;
    if (b == '0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
    end else begin
      e.q  = a / b;
      e.r  = a % b;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Result monitor: every Done must match the oldest outstanding request
  always @(negedge Clk) begin : monitor
    res_t e;
    if (bus.Done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        $display("txn done q=%h r=%h dz=%b (exp q=%h r=%h dz=%b)",
                 bus.Quotient, bus.Remainder, bus.DivZero, e.q, e.r, e.dz);
        chk("quotient", 64'(bus.Quotient), 64'(e.q));
        chk("remainder", 64'(bus.Remainder), 64'(e.r));
        chk("div_zero", 64'(bus.DivZero), 64'(e.dz));
      end
    end
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit interlock);
    res_t e;
    int   k;
    int   busy_n;
    int   exp_lat;
    e       = model(a, b);
    exp_lat = (b == '0) ? 1 : W;
    @(negedge Clk);
    bus.Start = 1'b1;
    bus.Funct = DIVU;
    bus.Src1  = a;
    bus.Src2  = b;
    exp_q.push_back(e);
    $display("txn start src1=%h src2=%h", a, b);
    @(negedge Clk);
    bus.Start = 1'b0;
    bus.Src1  = $urandom;
    bus.Src2  = $urandom;
    bus.Funct = 6'($urandom);
    k      = 0;
    busy_n = 0;
    while (bus.Done !== 1'b1 && k < 200) begin
      if (bus.Busy === 1'b1) busy_n++;
      if (interlock && k == 10) begin
        bus.Start = 1'b1;
        bus.Funct = DIVU;
        bus.Src1  = 32'h1234_5678;
        bus.Src2  = 32'h3;
      end else begin
        bus.Start = 1'b0;
      end
      k++;
      @(negedge Clk);
    end
    bus.Start = 1'b0;
    chk("latency", 64'(k), 64'(exp_lat));
    chk("busy_cycles", 64'(busy_n), 64'(exp_lat));
    chk("busy_at_done", 64'(bus.Busy), 64'd0);
    last_q = e.q;
    last_r = e.r;
    @(negedge Clk);
    chk("done_one_cycle", 64'(bus.Done), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    Reset     = 1'b1;
    bus.Start = 1'b0;
    bus.Funct = '0;
    bus.Src1  = '0;
    bus.Src2  = '0;
    #12;
    chk("rst_quotient", 64'(bus.Quotient), 64'd0);
    chk("rst_remainder", 64'(bus.Remainder), 64'd0);
    chk("rst_busy", 64'(bus.Busy), 64'd0);
    chk("rst_done", 64'(bus.Done), 64'd0);
    chk("rst_div_zero", 64'(bus.DivZero), 64'd0);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    chk("idle_busy", 64'(bus.Busy), 64'd0);

    run_op(32'd100, 32'd7, 1'b0);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op(32'd5, 32'd10, 1'b0);
    run_op(32'h1234, 32'd0, 1'b0);

    // Invalid function code: nothing starts and results hold
    @(negedge Clk);
    bus.Start = 1'b1;
    bus.Funct = 6'b000000;
    bus.Src1  = 32'h10;
    bus.Src2  = 32'h20;
    @(negedge Clk);
    bus.Start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bad_funct_busy", 64'(bus.Busy), 64'd0);
      chk("bad_funct_done", 64'(bus.Done), 64'd0);
      @(negedge Clk);
    end
    chk("hold_quotient", 64'(bus.Quotient), 64'(last_q));
    chk("hold_remainder", 64'(bus.Remainder), 64'(last_r));
    chk("hold_div_zero", 64'(bus.DivZero), 64'd1);
    $display("txn bad_funct ignored");

    run_op(32'h0F0F_0F1F, 32'h200, 1'b1);
    run_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_op(W'($urandom), (i == 0) ? W'($urandom) : W'($urandom_range(1, 1000)), 1'b0);
    end

    // Reset mid-operation: abort with no Done and cleared outputs
    @(negedge Clk);
    bus.Start = 1'b1;
    bus.Funct = DIVU;
    bus.Src1  = 32'd999;
    bus.Src2  = 32'd13;
    @(negedge Clk);
    bus.Start = 1'b0;
    repeat (15) @(negedge Clk);
    chk("busy_before_abort", 64'(bus.Busy), 64'd1);
    #2 Reset = 1'b1;
    #1;
    chk("abort_busy", 64'(bus.Busy), 64'd0);
    chk("abort_done", 64'(bus.Done), 64'd0);
    chk("abort_quotient", 64'(bus.Quotient), 64'd0);
    chk("abort_remainder", 64'(bus.Remainder), 64'd0);
    chk("abort_div_zero", 64'(bus.DivZero), 64'd0);
    $display("txn reset_mid_op");
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (40) @(negedge Clk);
    chk("abort_idle_busy", 64'(bus.Busy), 64'd0);

    run_op(32'd100, 32'd7, 1'b0);

    repeat (3) @(negedge Clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
